// File: rtl/home_status_tx.sv
// Panel-side status reporter: sends {A5, flags, cooler|temp, xor} as 8N1 bytes, LSB first,
// after reset, whenever the flag vector differs from the last report, and on a heartbeat.
module home_status_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int HEARTBEAT    = 4096
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] display,
  input  logic       fdoor,
  input  logic       rdoor,
  input  logic       winbuzz,
  input  logic       alarmbuzz,
  input  logic       heater,
  input  logic       cooler,
  input  logic [6:0] ST,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HBW = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
  localparam bit HB_EN = (HEARTBEAT > 0);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [HBW-1:0] HB_MAX  = HB_EN ? HBW'(HEARTBEAT - 1) : '0;
  localparam logic [7:0]     SYNC    = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Frame payload frozen at the trigger cycle; flags double as the last-sent vector.
  typedef struct packed {
    logic [7:0] flags;
    logic [7:0] temp;
  } snap_t;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [1:0]     byte_q, byte_d;
  logic [HBW-1:0] hb_q, hb_d;
  snap_t          snap_q, snap_d;
  logic           force_q, force_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [7:0] f_now;
  logic [7:0] cur_byte;
  logic       bit_end;
  logic       hb_hit;
  logic       trig;

  assign f_now   = {display, alarmbuzz, winbuzz, rdoor, fdoor, heater};
  assign bit_end = (cnt_q == CNT_MAX);
  assign hb_hit  = HB_EN && (hb_q == HB_MAX);
  assign trig    = (f_now != snap_q.flags) || force_q || hb_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    hb_d     = hb_q;
    snap_d   = snap_q;
    force_d  = force_q;
    done_d   = 1'b0;
    cur_byte = SYNC;

    unique case (state_q)
      IDLE: begin
        if (HB_EN && (hb_q != HB_MAX)) hb_d = hb_q + HBW'(1);
        if (trig) begin
          state_d      = START;
          cnt_d        = '0;
          bit_d        = '0;
          byte_d       = '0;
          hb_d         = '0;
          force_d      = 1'b0;
          snap_d.flags = f_now;
          snap_d.temp  = {cooler, ST};
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (byte_d)
      2'd0:    cur_byte = SYNC;
      2'd1:    cur_byte = snap_q.flags;
      2'd2:    cur_byte = snap_q.temp;
      default: cur_byte = SYNC ^ snap_q.flags ^ snap_q.temp;
    endcase

    // Line level is registered from the next state so tx/busy change one cycle after the decision.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      hb_q    <= '0;
      snap_q  <= '0;
      force_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      hb_q    <= hb_d;
      snap_q  <= snap_d;
      force_q <= force_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_home_status_tx.sv
// Bench for home_status_tx: decodes the serial line and compares against frames built from inputs.
module tb_home_status_tx;
  localparam int C  = 4;
  localparam int FL = 40 * C;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       rst_hb = 1'b1;
  logic [2:0] display = '0;
  logic       fdoor = 1'b0, rdoor = 1'b0, winbuzz = 1'b0, alarmbuzz = 1'b0;
  logic       heater = 1'b0, cooler = 1'b0;
  logic [6:0] ST = '0;
  logic       tx0, busy0, done0, tx1, busy1, done1;

  int         cyc = 0;
  int         n_chk = 0, n_pass = 0;
  logic [7:0] last_f = '0;

  logic [31:0] cap_b;
  int          cap_ts, cap_td, cap_se;
  bit          cap_got;
  int          flip_t1, flip_t2, flip_i1, flip_i2;

  home_status_tx #(.CLKS_PER_BIT(C), .HEARTBEAT(0)) u_dut (
    .Clk(Clk), .Rst(Rst), .display(display), .fdoor(fdoor), .rdoor(rdoor),
    .winbuzz(winbuzz), .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
    .ST(ST), .tx(tx0), .busy(busy0), .frame_done(done0));

  home_status_tx #(.CLKS_PER_BIT(C), .HEARTBEAT(50)) u_hb (
    .Clk(Clk), .Rst(rst_hb), .display(display), .fdoor(fdoor), .rdoor(rdoor),
    .winbuzz(winbuzz), .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
    .ST(ST), .tx(tx1), .busy(busy1), .frame_done(done1));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference frame straight from the report format: sync, flags, cooler|temp, xor of the three.
  function automatic logic [31:0] model_frame(input logic [7:0] f, input logic c, input logic [6:0] st);
    logic [7:0] b2, b3;
    b2 = {c, st};
    b3 = 8'hA5 ^ f ^ b2;
    return {b3, b2, f, 8'hA5};
  endfunction

  function automatic logic [7:0] get_f();
    return {display, alarmbuzz, winbuzz, rdoor, fdoor, heater};
  endfunction

  task automatic set_f(input logic [7:0] f);
    display = f[7:5]; alarmbuzz = f[4]; winbuzz = f[3];
    rdoor = f[2]; fdoor = f[1]; heater = f[0];
  endtask

  task automatic flip(input int idx);
    set_f(get_f() ^ (8'd1 << idx));
  endtask

  function automatic logic [7:0] new_f();
    logic [7:0] f;
    f = 8'($urandom);
    if (f == last_f) f = f ^ 8'h01;
    return f;
  endfunction

  function automatic logic line(input bit w);  return w ? tx1 : tx0;  endfunction
  function automatic logic bsy(input bit w);   return w ? busy1 : busy0; endfunction
  function automatic logic dn(input bit w);    return w ? done1 : done0; endfunction

  // Waits (bounded) for a start bit, samples the whole frame, decodes bytes, counts shape errors.
  task automatic capture(input bit w, input int timeout);
    logic smp[$];
    logic v;
    cap_got = 0; cap_se = 0; cap_b = '0; cap_ts = -1; cap_td = -1;
    for (int i = 0; i < timeout; i++) begin
      @(negedge Clk);
      if (line(w) === 1'b0) begin cap_got = 1; break; end
    end
    if (!cap_got) return;
    cap_ts = cyc;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge Clk);
      smp.push_back(line(w));
      if (bsy(w) !== 1'b1 || dn(w) !== 1'b0) cap_se++;
    end
    for (int k = 0; k < 40; k++) begin
      v = smp[k*C];
      for (int j = 1; j < C; j++) if (smp[k*C+j] !== v) cap_se++;
      if (k % 10 == 0) begin
        if (v !== 1'b0) cap_se++;
      end else if (k % 10 == 9) begin
        if (v !== 1'b1) cap_se++;
      end else if (v === 1'b1) begin
        cap_b = cap_b | (32'd1 << ((k / 10) * 8 + (k % 10) - 1));
      end
    end
    @(negedge Clk);
    cap_td = cyc;
    if (dn(w) !== 1'b1 || bsy(w) !== 1'b0 || line(w) !== 1'b1) cap_se++;
  endtask

  task automatic test_reset();
    int r, bad;
    set_f(8'h00); cooler = 0; ST = '0; Rst = 1;
    repeat (3) @(negedge Clk);
    n_chk++; if (tx0 !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx0); else n_pass++;
    n_chk++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
    n_chk++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b want 0", done0); else n_pass++;
    Rst = 0; r = cyc; last_f = 8'h00;
    capture(0, 10);
    n_chk++; if (cap_got !== 1'b1) $display("FAIL reset_frame_seen: got %b want 1", cap_got); else n_pass++;
    n_chk++; if (cap_ts != r + 1) $display("FAIL reset_start_cycle: got %0d want %0d", cap_ts, r + 1); else n_pass++;
    n_chk++; if (cap_b !== 32'hA50000A5) $display("FAIL reset_bytes: got %h want a50000a5", cap_b); else n_pass++;
    n_chk++; if (cap_se != 0) $display("FAIL reset_shape: got %0d errors want 0", cap_se); else n_pass++;
    n_chk++; if (cap_td != cap_ts + FL) $display("FAIL reset_done_cycle: got %0d want %0d", cap_td, cap_ts + FL); else n_pass++;
    bad = 0;
    repeat (300) begin @(negedge Clk); if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++; end
    n_chk++; if (bad != 0) $display("FAIL reset_idle_after: got %0d busy cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_change();
    logic [7:0] f;
    int s, bad;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin f = 8'hB0; cooler = 0; ST = 7'd25; end
      else begin f = new_f(); cooler = 1'($urandom); ST = 7'($urandom); end
      set_f(f); s = cyc;
      capture(0, 10);
      n_chk++; if (cap_ts != s + 1) $display("FAIL change_start[%0d]: got %0d want %0d", i, cap_ts, s + 1); else n_pass++;
      n_chk++; if (cap_b !== model_frame(f, cooler, ST))
        $display("FAIL change_bytes[%0d]: got %h want %h", i, cap_b, model_frame(f, cooler, ST)); else n_pass++;
      n_chk++; if (cap_se != 0) $display("FAIL change_shape[%0d]: got %0d errors want 0", i, cap_se); else n_pass++;
      last_f = f;
      repeat ($urandom_range(0, 4)) @(negedge Clk);
    end
    cooler = ~cooler; ST = ST + 7'd9; bad = 0;
    repeat (200) begin @(negedge Clk); if (tx0 !== 1'b1) bad++; end
    n_chk++; if (bad != 0) $display("FAIL st_only_no_frame: got %0d low cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_midframe();
    logic [7:0] f, f2;
    int s, td;
    for (int i = 0; i < 3; i++) begin
      f = new_f(); set_f(f); s = cyc;
      if (i == 0) begin flip_t1 = 21; flip_i1 = 1; flip_t2 = 0; flip_i2 = 0; end
      else begin
        flip_t1 = $urandom_range(5, 60); flip_i1 = $urandom_range(0, 7);
        flip_t2 = $urandom_range(5, 60); flip_i2 = (flip_i1 + $urandom_range(1, 7)) % 8;
      end
      fork
        capture(0, 10);
        begin
          repeat (flip_t1) @(negedge Clk);
          flip(flip_i1);
          if (flip_t2 > 0) begin repeat (flip_t2) @(negedge Clk); flip(flip_i2); end
        end
      join
      f2 = get_f(); td = cap_td;
      n_chk++; if (cap_ts != s + 1) $display("FAIL mid_start[%0d]: got %0d want %0d", i, cap_ts, s + 1); else n_pass++;
      n_chk++; if (cap_b !== model_frame(f, cooler, ST))
        $display("FAIL mid_inflight_bytes[%0d]: got %h want %h", i, cap_b, model_frame(f, cooler, ST)); else n_pass++;
      n_chk++; if (cap_se != 0) $display("FAIL mid_shape[%0d]: got %0d errors want 0", i, cap_se); else n_pass++;
      capture(0, 5);
      n_chk++; if (cap_ts != td + 1) $display("FAIL mid_followup_start[%0d]: got %0d want %0d", i, cap_ts, td + 1); else n_pass++;
      n_chk++; if (cap_b !== model_frame(f2, cooler, ST))
        $display("FAIL mid_followup_bytes[%0d]: got %h want %h", i, cap_b, model_frame(f2, cooler, ST)); else n_pass++;
      n_chk++; if (cap_se != 0) $display("FAIL mid_followup_shape[%0d]: got %0d errors want 0", i, cap_se); else n_pass++;
      last_f = f2;
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] f;
    int s, bad;
    f = new_f(); set_f(f); s = cyc;
    flip_t1 = 30; flip_i1 = 3; flip_t2 = 40; flip_i2 = 3;
    fork
      capture(0, 10);
      begin
        repeat (flip_t1) @(negedge Clk); flip(flip_i1);
        repeat (flip_t2) @(negedge Clk); flip(flip_i2);
      end
    join
    last_f = f;
    n_chk++; if (cap_b !== model_frame(f, cooler, ST))
      $display("FAIL glitch_bytes: got %h want %h", cap_b, model_frame(f, cooler, ST)); else n_pass++;
    bad = 0;
    repeat (200) begin @(negedge Clk); if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++; end
    n_chk++; if (bad != 0) $display("FAIL glitch_no_followup: got %0d busy cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f;
    int s, r;
    f = new_f(); set_f(f); s = cyc;
    repeat (58) @(negedge Clk);
    n_chk++; if (busy0 !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy0); else n_pass++;
    n_chk++; if (tx0 !== f[3]) $display("FAIL rstmid_b1_bit3: got %b want %b", tx0, f[3]); else n_pass++;
    Rst = 1;
    @(negedge Clk);
    n_chk++; if (tx0 !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", tx0); else n_pass++;
    n_chk++; if (busy0 !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy0); else n_pass++;
    n_chk++; if (done0 !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done0); else n_pass++;
    repeat (2) @(negedge Clk);
    Rst = 0; r = cyc;
    capture(0, 10);
    n_chk++; if (cap_ts != r + 1) $display("FAIL rstmid_restart: got %0d want %0d", cap_ts, r + 1); else n_pass++;
    n_chk++; if (cap_b !== model_frame(f, cooler, ST))
      $display("FAIL rstmid_bytes: got %h want %h", cap_b, model_frame(f, cooler, ST)); else n_pass++;
    n_chk++; if (cap_se != 0) $display("FAIL rstmid_shape: got %0d errors want 0", cap_se); else n_pass++;
    last_f = f;
  endtask

  task automatic test_heartbeat();
    logic [7:0] f;
    int r, d;
    cooler = 0; ST = 7'd20;
    repeat (2) @(negedge Clk);
    rst_hb = 0; r = cyc;
    capture(1, 10);
    n_chk++; if (cap_ts != r + 1) $display("FAIL hb_first_start: got %0d want %0d", cap_ts, r + 1); else n_pass++;
    n_chk++; if (cap_b !== model_frame(last_f, 1'b0, 7'd20))
      $display("FAIL hb_first_bytes: got %h want %h", cap_b, model_frame(last_f, 1'b0, 7'd20)); else n_pass++;
    d = cap_td;
    repeat (3) @(negedge Clk);
    ST = 7'd21;
    capture(1, 200);
    n_chk++; if (cap_ts != d + 50) $display("FAIL hb_period: got %0d want %0d", cap_ts, d + 50); else n_pass++;
    n_chk++; if (cap_b[23:16] !== 8'h15) $display("FAIL hb_b2: got %h want 15", cap_b[23:16]); else n_pass++;
    n_chk++; if (cap_se != 0) $display("FAIL hb_shape: got %0d errors want 0", cap_se); else n_pass++;
    d = cap_td;
    repeat (49) @(negedge Clk);
    n_chk++; if (busy1 !== 1'b0) $display("FAIL hb_idle_before_expiry: got %b want 0", busy1); else n_pass++;
    f = new_f(); set_f(f);
    capture(1, 5);
    n_chk++; if (cap_ts != d + 50) $display("FAIL hb_coincide_start: got %0d want %0d", cap_ts, d + 50); else n_pass++;
    n_chk++; if (cap_b !== model_frame(f, 1'b0, 7'd21))
      $display("FAIL hb_coincide_bytes: got %h want %h", cap_b, model_frame(f, 1'b0, 7'd21)); else n_pass++;
    d = cap_td;
    capture(1, 200);
    n_chk++; if (cap_ts != d + 50) $display("FAIL hb_restart_period: got %0d want %0d", cap_ts, d + 50); else n_pass++;
    n_chk++; if (cap_b !== model_frame(f, 1'b0, 7'd21))
      $display("FAIL hb_restart_bytes: got %h want %h", cap_b, model_frame(f, 1'b0, 7'd21)); else n_pass++;
    last_f = f;
  endtask

  initial begin
    test_reset();
    test_change();
    test_midframe();
    test_glitch();
    test_reset_midframe();
    test_heartbeat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/home_status_tx.md
Name: home_status_tx

Overview:
- Serial status transmitter for the smart-home controller. It is the panel-side end of the controller's actuator/display outputs.
- Monitors display code, actuator flags and the raw temperature bus, and sends a framed UART-style report (8N1, LSB first) to the wall panel.
- A report goes out on any change of the monitored flags, and also on a periodic heartbeat.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
HEARTBEAT, 4096, idle cycles between unconditional reports; 0 disables heartbeat

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  synchronous, active-high reset
display  input  3  controller state/display code
fdoor  input  1  front door actuator
rdoor  input  1  rear door actuator
winbuzz  input  1  window buzzer
alarmbuzz  input  1  fire alarm buzzer
heater  input  1  heater on
cooler  input  1  cooler on
ST  input  7  temperature, unsigned
tx  output  1  serial line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset: Rst is sampled on Clk only. Reset values: tx=1, busy=0, frame_done=0, state=IDLE, all counters=0, last-sent snapshot=0, force_send=1.
- Reset mid-frame aborts the frame. tx returns high on the next edge; no partial byte is completed.
- Flag vector F = {display[2:0], alarmbuzz, winbuzz, rdoor, fdoor, heater}.
- ST is excluded from change detection. It is only sampled into the frame.
- Trigger, evaluated only in IDLE, in cycle N. Any of the following triggers a frame:
  - F != last-sent F;
  - force_send=1;
  - HEARTBEAT>0 and the heartbeat counter has reached HEARTBEAT-1.
- Snapshot at trigger cycle N:
  - capture F, cooler and ST;
  - last-sent F <= F;
  - force_send <= 0;
  - heartbeat counter <= 0;
  - go to START.
- The heartbeat counter increments only in IDLE and saturates at HEARTBEAT-1.
- Frame format, 4 bytes, in this order:
  - B0 = 8'hA5;
  - B1 = F;
  - B2 = {cooler, ST[6:0]};
  - B3 = B0^B1^B2.
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). Every bit is held for exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx = current bit; bit index 0..7.
  - STOP: tx=1. At the end of STOP, advance to START of the next byte if byte index < 3. After byte 3, return to IDLE.
- Timing:
  - tx and busy are registered. From cycle N+1, tx=0 and busy=1.
  - The frame lasts 40*CLKS_PER_BIT cycles, N+1 through N+40*CLKS_PER_BIT.
  - frame_done=1 and busy=0 in cycle N+40*CLKS_PER_BIT+1 (first IDLE cycle).
  - The earliest next trigger is evaluated in that same cycle, so the next frame's start bit can appear at N+40*CLKS_PER_BIT+2. The minimum gap is one idle-high cycle.
- Inputs changing mid-frame do not alter the frame in flight. Because last-sent F holds the old value, the change retriggers in the first IDLE cycle.
- A change that reverts before the frame ends causes no extra frame.
- Multiple changes during one frame produce exactly one follow-up frame, carrying the value present in that IDLE cycle.
- Simultaneous heartbeat expiry and change produce one frame; the heartbeat counter restarts.
- No back-pressure. The frame is never stalled or truncated except by Rst.

Test Plan:
1. Reset then idle, CLKS_PER_BIT=4, HEARTBEAT=0. Inputs are all 0. Release Rst at cycle 0 → force_send trigger at cycle 1. tx=0 for cycles 2..5. Bytes A5,00,00,A5. frame_done at cycle 162. tx then stays 1 indefinitely.
2. Change report. Set display=3'b101, alarmbuzz=1, others 0, ST=25 → frame bytes A5,B0,19,0C. Every bit is exactly 4 cycles; each stop bit is 1.
3. Mid-frame change. Toggle fdoor at cycle 20 of a frame → the current frame is unchanged. A second frame starts 1 idle cycle after frame_done, with B1 bit1 set.
4. Glitch absorbed. Toggle winbuzz high then low, both during a frame → no follow-up frame; tx stays 1 after frame_done.
5. Heartbeat. HEARTBEAT=50, inputs static, ST changed from 20 to 21 → the next frame starts 50 cycles after the previous frame_done, with B2=0x15. ST alone never triggers earlier.
6. Reset mid-frame. Assert Rst during data bit 3 of B1 → tx=1, busy=0 on the next edge. After release, a fresh full frame is sent (force_send).
